// File: rtl/kp_pkg.sv
// Shared types for the keypad scanner: FSM state encoding and snapshot classes.
package kp_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DEB_PRESS = 2'd1,
        HELD      = 2'd2,
        DEB_REL   = 2'd3
    } kp_state_t;

    typedef enum logic [1:0] {
        NONE   = 2'd0,
        SINGLE = 2'd1,
        MULTI  = 2'd2
    } snap_class_t;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int unsigned width_of(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/kp_event_reg.sv
// One-entry valid/ready event register; a load while stalled is dropped and flagged.
module kp_event_reg #(
    parameter int unsigned CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_code,
    input  logic          ready,
    output logic          valid,
    output logic [CW-1:0] code,
    output logic          ovf
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            code  <= '0;
            ovf   <= 1'b0;
        end else if (valid && !ready) begin
            // Pending event is frozen; anything new is lost.
            if (load) begin
                ovf <= 1'b1;
            end
        end else if (load) begin
            valid <= 1'b1;
            code  <= load_code;
        end else begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// Column-scanning keypad controller with debounce, auto-repeat and a
// one-entry event output.
module keypad_scanner
    import kp_pkg::*;
#(
    parameter int unsigned N_ROWS   = 4,
    parameter int unsigned N_COLS   = 4,
    parameter int unsigned SCAN_DIV = 16,
    parameter int unsigned DEBOUNCE = 3,
    parameter int unsigned REP_DLY  = 40,
    parameter int unsigned REP_RATE = 10,
    parameter int unsigned CW       = $clog2(N_ROWS * N_COLS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_ROWS-1:0] rows,
    input  logic              rep_en,
    output logic [N_COLS-1:0] cols,
    output logic              key_valid,
    input  logic              key_ready,
    output logic [CW-1:0]     key_code,
    output logic              key_held,
    output logic              multi_err,
    output logic              ovf
);

    localparam int unsigned SW    = width_of(SCAN_DIV);
    localparam int unsigned COLW  = width_of(N_COLS);
    localparam int unsigned DW    = width_of(DEBOUNCE + 1);
    localparam int unsigned RPMAX = (REP_DLY > REP_RATE) ? REP_DLY : REP_RATE;
    localparam int unsigned RPW   = width_of(RPMAX + 1);

    logic [SW-1:0]   slot;
    logic [COLW-1:0] col_idx;
    logic [COLW-1:0] col_next;
    logic [1:0]      snap_cnt;
    logic [CW-1:0]   snap_code;
    logic            sample;
    logic            scan_end;

    int              row_hits;
    int              row_idx;
    int              hits_total;
    logic [1:0]      cur_cnt;
    logic [CW-1:0]   cur_code;
    snap_class_t     cls;

    kp_state_t       state, state_next;
    logic [CW-1:0]   cand, cand_next;
    logic [DW-1:0]   deb_cnt, deb_next, deb_inc;
    logic [RPW-1:0]  rep_cnt, rep_next, rep_inc;
    logic            rep_phase, phase_next;
    logic            match;
    logic            emit;

    assign sample   = (slot == SW'(SCAN_DIV - 1));
    assign scan_end = sample && (col_idx == COLW'(N_COLS - 1));
    assign col_next = (col_idx == COLW'(N_COLS - 1)) ? '0 : col_idx + COLW'(1);

    // Fold the current column's rows into the running snapshot (count saturates at 2).
    always_comb begin
        row_hits = 0;
        row_idx  = 0;
        for (int r = 0; r < int'(N_ROWS); r++) begin
            if (rows[r]) begin
                row_hits = row_hits + 1;
                row_idx  = r;
            end
        end
        hits_total = int'(snap_cnt) + row_hits;
        cur_cnt    = (hits_total >= 2) ? 2'd2 : 2'(hits_total);
        cur_code   = snap_code;
        if (snap_cnt == 2'd0 && row_hits == 1) begin
            cur_code = CW'(int'(col_idx) * int'(N_ROWS) + row_idx);
        end
        cls = NONE;
        if (cur_cnt == 2'd1) begin
            cls = SINGLE;
        end else if (cur_cnt == 2'd2) begin
            cls = MULTI;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot      <= '0;
            col_idx   <= '0;
            cols      <= N_COLS'(1);
            snap_cnt  <= 2'd0;
            snap_code <= '0;
        end else begin
            slot <= sample ? '0 : slot + SW'(1);
            if (sample) begin
                col_idx <= col_next;
                cols    <= N_COLS'(1) << col_next;
                // A finished scan starts the next snapshot from empty.
                snap_cnt  <= scan_end ? 2'd0 : cur_cnt;
                snap_code <= scan_end ? '0 : cur_code;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cand      <= '0;
            deb_cnt   <= '0;
            rep_cnt   <= '0;
            rep_phase <= 1'b0;
            key_held  <= 1'b0;
            multi_err <= 1'b0;
        end else begin
            state     <= state_next;
            cand      <= cand_next;
            deb_cnt   <= deb_next;
            rep_cnt   <= rep_next;
            rep_phase <= phase_next;
            key_held  <= (state_next == HELD) || (state_next == DEB_REL);
            multi_err <= multi_err | (scan_end && cls == MULTI);
        end
    end

    // Debounce / repeat decisions, taken once per completed snapshot.
    always_comb begin
        state_next = state;
        cand_next  = cand;
        deb_next   = deb_cnt;
        rep_next   = rep_cnt;
        phase_next = rep_phase;
        emit       = 1'b0;
        match      = (cls == SINGLE) && (cur_code == cand);
        deb_inc    = deb_cnt + DW'(1);
        rep_inc    = rep_cnt + RPW'(1);
        if (scan_end) begin
            case (state)
                IDLE: begin
                    if (cls == SINGLE) begin
                        cand_next  = cur_code;
                        deb_next   = DW'(1);
                        rep_next   = '0;
                        phase_next = 1'b0;
                        if (DEBOUNCE <= 1) begin
                            state_next = HELD;
                            emit       = 1'b1;
                        end else begin
                            state_next = DEB_PRESS;
                        end
                    end
                end
                DEB_PRESS: begin
                    if (match) begin
                        deb_next = deb_inc;
                        if (deb_inc == DW'(DEBOUNCE)) begin
                            state_next = HELD;
                            emit       = 1'b1;
                            deb_next   = '0;
                            rep_next   = '0;
                            phase_next = 1'b0;
                        end
                    end else begin
                        state_next = IDLE;
                        deb_next   = '0;
                    end
                end
                HELD: begin
                    if (match) begin
                        if (rep_en) begin
                            rep_next = rep_inc;
                            if ((!rep_phase && rep_inc == RPW'(REP_DLY)) ||
                                (rep_phase && rep_inc == RPW'(REP_RATE))) begin
                                emit       = 1'b1;
                                rep_next   = '0;
                                phase_next = 1'b1;
                            end
                        end
                    end else if (DEBOUNCE <= 1) begin
                        state_next = IDLE;
                    end else begin
                        state_next = DEB_REL;
                        deb_next   = DW'(1);
                    end
                end
                DEB_REL: begin
                    if (match) begin
                        state_next = HELD;
                        deb_next   = '0;
                    end else begin
                        deb_next = deb_inc;
                        if (deb_inc == DW'(DEBOUNCE)) begin
                            state_next = IDLE;
                            deb_next   = '0;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    kp_event_reg #(.CW(CW)) u_event_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (emit),
        .load_code (cur_code),
        .ready     (key_ready),
        .valid     (key_valid),
        .code      (key_code),
        .ovf       (ovf)
    );

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a keypad model drives rows from cols,
// and a per-scan behavioural model predicts events, key_held and multi_err.
module tb_keypad_scanner;

    localparam int NR   = 4;
    localparam int NC   = 4;
    localparam int SD   = 16;
    localparam int DEB  = 3;
    localparam int RD   = 40;
    localparam int RR   = 10;
    localparam int SCAN = NC * SD;

    logic          clk = 1'b0;
    logic          rst;
    logic [NR-1:0] rows;
    logic          rep_en;
    logic [NC-1:0] cols;
    logic          key_valid;
    logic          key_ready;
    logic [3:0]    key_code;
    logic          key_held;
    logic          multi_err;
    logic          ovf;
    logic [15:0]   keys;

    int total = 0;
    int bad   = 0;

    // Model state: held key (-1 none), candidate (-1 none), run/release/age counters.
    int m_held, m_cand, m_run, m_rel, m_age;
    bit m_multi;

    always #5 clk = ~clk;

    // Physical keypad: a pressed key connects its column drive to its row.
    always_comb begin
        rows = '0;
        for (int c = 0; c < NC; c++) begin
            if (cols[c]) rows = rows | keys[c*NR +: NR];
        end
    end

    keypad_scanner #(
        .N_ROWS(NR), .N_COLS(NC), .SCAN_DIV(SD), .DEBOUNCE(DEB),
        .REP_DLY(RD), .REP_RATE(RR), .CW(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rows      (rows),
        .rep_en    (rep_en),
        .cols      (cols),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_code  (key_code),
        .key_held  (key_held),
        .multi_err (multi_err),
        .ovf       (ovf)
    );

    // -1: no key, -2: several keys, otherwise the key code.
    function automatic int snap_of(input logic [15:0] k);
        int n   = 0;
        int idx = -1;
        for (int i = 0; i < 16; i++) begin
            if (k[i]) begin
                n++;
                idx = i;
            end
        end
        if (n == 0) return -1;
        if (n == 1) return idx;
        return -2;
    endfunction

    task automatic model_clear();
        m_held = -1; m_cand = -1; m_run = 0; m_rel = 0; m_age = 0; m_multi = 0;
    endtask

    task automatic model_step(input int snap, input bit rep, output bit ev, output int code);
        int s = snap;
        ev   = 0;
        code = 0;
        if (s == -2) begin
            m_multi = 1;
            s = -1;
        end
        if (m_held < 0) begin
            if (m_cand >= 0) begin
                if (s == m_cand) m_run++;
                else m_cand = -1;
            end else if (s >= 0) begin
                m_cand = s;
                m_run  = 1;
            end
            if (m_cand >= 0 && m_run >= DEB) begin
                m_held = m_cand;
                m_cand = -1;
                m_age  = 0;
                m_rel  = 0;
                ev     = 1;
                code   = m_held;
            end
        end else if (s == m_held) begin
            if (m_rel > 0) begin
                m_rel = 0;
            end else if (rep) begin
                m_age++;
                if (m_age == RD || (m_age > RD && (m_age - RD) % RR == 0)) begin
                    ev   = 1;
                    code = m_held;
                end
            end
        end else begin
            m_rel++;
            if (m_rel >= DEB) begin
                m_held = -1;
                m_rel  = 0;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1; keys = '0; rep_en = 0; key_ready = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        model_clear();
    endtask

    // One full scan with a fixed key set; checks the result at the scan boundary.
    task automatic do_scan(input logic [15:0] k, input string tag, input bit chk, output bit ev);
        int code;
        keys = k;
        repeat (SCAN) @(posedge clk);
        @(negedge clk);
        model_step(snap_of(k), rep_en, ev, code);
        if (chk) begin
            total++;
            if (key_valid !== ev) begin
                bad++;
                $display("FAIL %s key_valid: got %0b want %0b", tag, key_valid, ev);
            end
            if (ev) begin
                total++;
                if (key_code !== 4'(code)) begin
                    bad++;
                    $display("FAIL %s key_code: got %0d want %0d", tag, key_code, code);
                end
            end
            total++;
            if (key_held !== (m_held >= 0)) begin
                bad++;
                $display("FAIL %s key_held: got %0b want %0b", tag, key_held, m_held >= 0);
            end
            total++;
            if (multi_err !== m_multi) begin
                bad++;
                $display("FAIL %s multi_err: got %0b want %0b", tag, multi_err, m_multi);
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (cols !== 4'b0001 || key_valid !== 0 || key_code !== 0 || key_held !== 0 ||
            multi_err !== 0 || ovf !== 0) begin
            bad++;
            $display("FAIL reset outputs: got cols=%b v=%b code=%0d held=%b me=%b ovf=%b want 0001/0/0/0/0/0",
                     cols, key_valid, key_code, key_held, multi_err, ovf);
        end
    endtask

    task automatic test_scan();
        logic [NC-1:0] want;
        do_reset();
        for (int i = 0; i < 2 * SCAN; i++) begin
            want = NC'(1) << ((i / SD) % NC);
            total++;
            if (cols !== want) begin
                bad++;
                $display("FAIL scan cols cycle %0d: got %b want %b", i, cols, want);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_press();
        bit ev;
        do_reset();
        for (int s = 1; s <= 3; s++) do_scan(16'h0200, "press", 1, ev);
        total++;
        if (key_valid !== 1 || key_code !== 4'd9 || key_held !== 1) begin
            bad++;
            $display("FAIL press code9: got v=%b code=%0d held=%b want 1/9/1", key_valid, key_code, key_held);
        end
    endtask

    task automatic test_bounce();
        logic [15:0] seq [6] = '{16'h0200, 16'h0200, 16'h0000, 16'h0200, 16'h0200, 16'h0200};
        bit ev;
        int events = 0;
        do_reset();
        for (int s = 0; s < 6; s++) begin
            do_scan(seq[s], "bounce", 1, ev);
            if (key_valid === 1'b1) events++;
        end
        total++;
        if (events !== 1) begin
            bad++;
            $display("FAIL bounce event count: got %0d want 1", events);
        end
    endtask

    task automatic test_repeat();
        bit ev, want;
        do_reset();
        rep_en = 1;
        for (int s = 1; s <= 63; s++) begin
            do_scan(16'h0200, "repeat", 1, ev);
            want = (s == 3 || s == 43 || s == 53 || s == 63);
            total++;
            if (key_valid !== want) begin
                bad++;
                $display("FAIL repeat schedule scan %0d: got %0b want %0b", s, key_valid, want);
            end
        end
        rep_en = 0;
        for (int s = 0; s < 12; s++) do_scan(16'h0200, "repeat_off", 1, ev);
        for (int s = 0; s < 3; s++) do_scan(16'h0000, "repeat_rel", 1, ev);
    endtask

    task automatic test_multi();
        bit ev;
        do_reset();
        for (int s = 0; s < 4; s++) do_scan(16'h0021, "multi", 1, ev);
        for (int s = 0; s < 4; s++) do_scan(16'h0000, "multi_rel", 1, ev);
        total++;
        if (multi_err !== 1 || key_valid !== 0) begin
            bad++;
            $display("FAIL multi sticky: got me=%b v=%b want 1/0", multi_err, key_valid);
        end
    endtask

    task automatic test_overflow();
        bit ev;
        do_reset();
        key_ready = 0;
        for (int s = 0; s < 3; s++) do_scan(16'h0200, "ovf", 0, ev);
        for (int s = 0; s < 3; s++) do_scan(16'h0000, "ovf", 0, ev);
        for (int s = 0; s < 3; s++) do_scan(16'h0004, "ovf", 0, ev);
        total++;
        if (key_valid !== 1 || key_code !== 4'd9 || ovf !== 1) begin
            bad++;
            $display("FAIL ovf pending: got v=%b code=%0d ovf=%b want 1/9/1", key_valid, key_code, ovf);
        end
        key_ready = 1;
        @(posedge clk);
        @(negedge clk);
        total++;
        if (key_valid !== 0) begin
            bad++;
            $display("FAIL ovf drain: got v=%b want 0", key_valid);
        end
        repeat (5) @(negedge clk);
        total++;
        if (key_valid !== 0 || ovf !== 1) begin
            bad++;
            $display("FAIL ovf after drain: got v=%b ovf=%b want 0/1", key_valid, ovf);
        end
    endtask

    task automatic test_reset_mid();
        bit ev;
        do_reset();
        key_ready = 0;
        for (int s = 0; s < 3; s++) do_scan(16'h0200, "rstmid", 0, ev);
        repeat (40) @(posedge clk);
        @(negedge clk);
        rst = 1;
        @(posedge clk);
        @(negedge clk);
        total++;
        if (cols !== 4'b0001 || key_valid !== 0 || key_held !== 0 || ovf !== 0) begin
            bad++;
            $display("FAIL reset mid-scan: got cols=%b v=%b held=%b ovf=%b want 0001/0/0/0",
                     cols, key_valid, key_held, ovf);
        end
        rst = 0;
        key_ready = 1;
        model_clear();
        for (int s = 0; s < 3; s++) do_scan(16'h0200, "rstmid_after", 1, ev);
    endtask

    task automatic test_random();
        bit ev;
        int scans = 0;
        int r, len, a, b;
        logic [15:0] k;
        do_reset();
        while (scans < 60) begin
            r = $urandom_range(0, 9);
            if (r < 4) begin
                k = '0;
            end else if (r < 9) begin
                k = 16'(1) << $urandom_range(0, 15);
            end else begin
                a = $urandom_range(0, 15);
                b = (a + 1 + $urandom_range(0, 14)) % 16;
                k = (16'(1) << a) | (16'(1) << b);
            end
            len = $urandom_range(1, 5);
            for (int i = 0; i < len; i++) do_scan(k, "random", 1, ev);
            scans += len;
        end
    endtask

    initial begin
        rst = 1; keys = '0; rep_en = 0; key_ready = 1;
        test_reset();
        test_scan();
        test_press();
        test_bounce();
        test_repeat();
        test_multi();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
